// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I R-type controller.
package riscv_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_t;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// Instruction handshake plus register-file / ALU control bundle of the controller.
interface riscv_mc_ctrl_if #(parameter int CNT_W = 32) ();

  logic             instr_valid;
  logic [31:0]      instr;
  logic             halt;
  logic             instr_ready;
  logic [4:0]       rf_rs1;
  logic [4:0]       rf_rs2;
  logic [4:0]       rf_rd;
  logic             rf_we;
  logic [3:0]       alu_ctrl;
  logic             busy;
  logic             illegal;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output instr_valid, instr, halt,
    input  instr_ready, rf_rs1, rf_rs2, rf_rd, rf_we, alu_ctrl, busy, illegal, retire_cnt
  );

  modport slave (
    input  instr_valid, instr, halt,
    output instr_ready, rf_rs1, rf_rs2, rf_rd, rf_we, alu_ctrl, busy, illegal, retire_cnt
  );

endinterface

// File: rtl/riscv_rtype_decoder.sv
// Purely combinational funct7/funct3 -> ALU op decode; zero latency, no handshake.
module riscv_rtype_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b0;
    if (funct7 == F7_BASE) begin
      legal = 1'b1;
      case (funct3)
        3'b000:  alu_ctrl = ALU_ADD;
        3'b001:  alu_ctrl = ALU_SLL;
        3'b010:  alu_ctrl = ALU_SLT;
        3'b011:  alu_ctrl = ALU_SLTU;
        3'b100:  alu_ctrl = ALU_XOR;
        3'b101:  alu_ctrl = ALU_SRL;
        3'b110:  alu_ctrl = ALU_OR;
        default: alu_ctrl = ALU_AND;
      endcase
    end else if (funct7 == F7_ALT) begin
      // Only SUB and SRA exist in the alternate encoding space
      if (funct3 == 3'b000) begin
        legal    = 1'b1;
        alu_ctrl = ALU_SUB;
      end else if (funct3 == 3'b101) begin
        legal    = 1'b1;
        alu_ctrl = ALU_SRA;
      end
    end
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle R-type controller IDLE->DECODE->EXEC->WB: accept at N, rf_we at N+3, one instr per 4 cycles.
// Upstream is stalled (instr_ready low) whenever busy, in reset, or while halt is high.
module riscv_mc_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  riscv_mc_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  rtype_t           ir_q;
  logic [3:0]       alu_q;
  logic             rf_we_q, rf_we_d;
  logic             illegal_q, illegal_d;
  logic             alu_ld;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       dec_alu;
  logic             dec_legal;
  logic             legal;
  logic             accept;

  riscv_rtype_decoder u_dec (
    .funct7   (ir_q.funct7),
    .funct3   (ir_q.funct3),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  assign legal  = dec_legal && (ir_q.opcode == OPC_RTYPE);
  assign accept = bus.instr_valid && bus.instr_ready;

  always_comb begin
    state_d   = state_q;
    rf_we_d   = 1'b0;
    illegal_d = 1'b0;
    alu_ld    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (legal) begin
          alu_ld  = 1'b1;
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_EXEC: begin
        // Writes to x0 are dropped but the instruction still retires
        rf_we_d = (ir_q.rd != 5'd0);
        state_d = S_WB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      alu_q     <= ALU_ADD;
      rf_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rf_we_q   <= rf_we_d;
      illegal_q <= illegal_d;
      if (accept) ir_q <= bus.instr;
      if (alu_ld) alu_q <= dec_alu;
      if (state_q == S_WB) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.instr_ready = rst_n && (state_q == S_IDLE) && !bus.halt;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.rf_rs1      = ir_q.rs1;
  assign bus.rf_rs2      = ir_q.rs2;
  assign bus.rf_rd       = ir_q.rd;
  assign bus.rf_we       = rf_we_q;
  assign bus.alu_ctrl    = alu_q;
  assign bus.illegal     = illegal_q;
  assign bus.retire_cnt  = cnt_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed table-driven bench for riscv_mc_ctrl plus halt, reset-in-EXEC and counter-wrap sequences.
module tb_riscv_mc_ctrl;

  localparam int CW = 4;

  logic clk;
  logic rst_n;

  riscv_mc_ctrl_if #(.CNT_W(CW)) bus ();

  riscv_mc_ctrl #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  alu;
    logic        legal;
    logic        we;
    logic [4:0]  rd;
  } vec_t;

  vec_t vt[14];
  int n_cmp = 0;
  int n_err = 0;
  logic [CW-1:0] exp_cnt;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one time unit after an edge with the controller idle
  task automatic run_vec(input vec_t v);
    logic [31:0] ins;
    ins = v.ins;
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    chk("ready_idle", bus.instr_ready, 1);
    tick();
    bus.instr       = 32'hFFFF_FFFF;
    bus.instr_valid = v.legal;
    chk("busy_dec", bus.busy, 1);
    chk("ready_dec", bus.instr_ready, 0);
    chk("rs1", bus.rf_rs1, ins[19:15]);
    chk("rs2", bus.rf_rs2, ins[24:20]);
    chk("rd_dec", bus.rf_rd, ins[11:7]);
    tick();
    if (!v.legal) begin
      chk("illegal_pulse", bus.illegal, 1);
      chk("busy_after_illegal", bus.busy, 0);
      chk("we_illegal", bus.rf_we, 0);
      bus.instr_valid = 1'b0;
      tick();
      chk("illegal_end", bus.illegal, 0);
      chk("we_illegal2", bus.rf_we, 0);
      chk("cnt_illegal", bus.retire_cnt, exp_cnt);
    end else begin
      chk("alu_exec", bus.alu_ctrl, v.alu);
      chk("illegal_exec", bus.illegal, 0);
      chk("busy_exec", bus.busy, 1);
      tick();
      chk("we_wb", bus.rf_we, v.we);
      chk("rd_wb", bus.rf_rd, v.rd);
      chk("alu_wb", bus.alu_ctrl, v.alu);
      bus.instr_valid = 1'b0;
      exp_cnt = exp_cnt + 1'b1;
      tick();
      chk("cnt_retire", bus.retire_cnt, exp_cnt);
      chk("ready_after", bus.instr_ready, 1);
      chk("we_after", bus.rf_we, 0);
      chk("alu_hold", bus.alu_ctrl, v.alu);
    end
  endtask

  initial begin
    vt[0]  = '{mk(7'b0000000, 5'd2,  5'd1,  3'b000, 5'd3,  7'b0110011), 4'b0000, 1'b1, 1'b1, 5'd3};
    vt[1]  = '{mk(7'b0100000, 5'd4,  5'd2,  3'b000, 5'd5,  7'b0110011), 4'b0001, 1'b1, 1'b1, 5'd5};
    vt[2]  = '{mk(7'b0100000, 5'd7,  5'd6,  3'b101, 5'd8,  7'b0110011), 4'b0110, 1'b1, 1'b1, 5'd8};
    vt[3]  = '{mk(7'b0000000, 5'd9,  5'd10, 3'b001, 5'd11, 7'b0110011), 4'b0111, 1'b1, 1'b1, 5'd11};
    vt[4]  = '{mk(7'b0000000, 5'd12, 5'd13, 3'b010, 5'd14, 7'b0110011), 4'b1000, 1'b1, 1'b1, 5'd14};
    vt[5]  = '{mk(7'b0000000, 5'd15, 5'd16, 3'b011, 5'd17, 7'b0110011), 4'b1001, 1'b1, 1'b1, 5'd17};
    vt[6]  = '{mk(7'b0000000, 5'd18, 5'd19, 3'b100, 5'd20, 7'b0110011), 4'b0100, 1'b1, 1'b1, 5'd20};
    vt[7]  = '{mk(7'b0000000, 5'd21, 5'd22, 3'b101, 5'd23, 7'b0110011), 4'b0101, 1'b1, 1'b1, 5'd23};
    vt[8]  = '{mk(7'b0000000, 5'd24, 5'd25, 3'b110, 5'd26, 7'b0110011), 4'b0011, 1'b1, 1'b1, 5'd26};
    vt[9]  = '{mk(7'b0000000, 5'd27, 5'd28, 3'b111, 5'd29, 7'b0110011), 4'b0010, 1'b1, 1'b1, 5'd29};
    vt[10] = '{mk(7'b0100000, 5'd1,  5'd2,  3'b111, 5'd3,  7'b0110011), 4'b0000, 1'b0, 1'b0, 5'd3};
    vt[11] = '{mk(7'b0000000, 5'd5,  5'd1,  3'b000, 5'd4,  7'b0010011), 4'b0000, 1'b0, 1'b0, 5'd4};
    vt[12] = '{mk(7'b0000001, 5'd2,  5'd1,  3'b000, 5'd6,  7'b0110011), 4'b0000, 1'b0, 1'b0, 5'd6};
    vt[13] = '{mk(7'b0000000, 5'd2,  5'd1,  3'b000, 5'd0,  7'b0110011), 4'b0000, 1'b1, 1'b0, 5'd0};

    exp_cnt         = '0;
    rst_n           = 1'b0;
    bus.halt        = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr       = vt[0].ins;
    tick(); tick(); tick();
    chk("rst_ready", bus.instr_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.retire_cnt, 0);
    chk("rst_alu", bus.alu_ctrl, 0);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_ir", bus.rf_rd, 0);
    bus.instr_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", bus.instr_ready, 1);
    chk("post_rst_busy", bus.busy, 0);

    for (int i = 0; i < 14; i++) run_vec(vt[i]);

    // halt raised during EXEC must not cancel write-back
    bus.instr_valid = 1'b1;
    bus.instr = mk(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011);
    tick();
    bus.instr = 32'hFFFF_FFFF;
    tick();
    chk("halt_exec_busy", bus.busy, 1);
    bus.halt = 1'b1;
    tick();
    chk("halt_we", bus.rf_we, 1);
    chk("halt_rd", bus.rf_rd, 7);
    exp_cnt = exp_cnt + 1'b1;
    tick();
    chk("halt_ready0", bus.instr_ready, 0);
    chk("halt_busy0", bus.busy, 0);
    chk("halt_cnt", bus.retire_cnt, exp_cnt);
    tick();
    chk("halt_ready0b", bus.instr_ready, 0);
    chk("halt_no_accept", bus.busy, 0);
    bus.instr_valid = 1'b0;
    bus.halt = 1'b0;
    tick();
    chk("unhalt_ready", bus.instr_ready, 1);

    // reset while in EXEC abandons the instruction
    bus.instr_valid = 1'b1;
    bus.instr = mk(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd9, 7'b0110011);
    tick();
    bus.instr_valid = 1'b0;
    tick();
    chk("rstx_exec_busy", bus.busy, 1);
    rst_n = 1'b0;
    tick();
    chk("rstx_busy", bus.busy, 0);
    chk("rstx_we", bus.rf_we, 0);
    chk("rstx_cnt", bus.retire_cnt, 0);
    chk("rstx_ready", bus.instr_ready, 0);
    exp_cnt = '0;
    rst_n = 1'b1;
    tick();
    chk("rstx_ready1", bus.instr_ready, 1);
    chk("rstx_we2", bus.rf_we, 0);
    chk("rstx_cnt2", bus.retire_cnt, 0);

    // drive the counter to all-ones, then one more retire wraps it
    for (int i = 0; i < 15; i++) run_vec(vt[0]);
    chk("cnt_all_ones", bus.retire_cnt, 4'hF);
    run_vec(vt[13]);
    chk("cnt_wrap", bus.retire_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_mc_ctrl.md
RISCV_MC_CTRL -- requirements
Module: riscv_mc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port instr_valid  input  1  upstream has an instruction on instr.
REQ-005 SHALL have port instr  input  32  RV32I instruction word.
REQ-006 SHALL have port halt  input  1  stop accepting new instructions after the current one completes.
REQ-007 SHALL have port instr_ready  output  1  controller accepts instr this cycle.
REQ-008 SHALL have port rf_rs1  output  5  register-file read address 1, equal to IR[19:15].
REQ-009 SHALL have port rf_rs2  output  5  register-file read address 2, equal to IR[24:20].
REQ-010 SHALL have port rf_rd  output  5  register-file write address, equal to IR[11:7].
REQ-011 SHALL have port rf_we  output  1  register-file write enable.
REQ-012 SHALL have port alu_ctrl  output  4  ALU operation select.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port illegal  output  1  one-cycle pulse when a rejected instruction is detected.
REQ-015 SHALL have port retire_cnt  output  CNT_W  count of instructions that reached WB.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, DECODE, EXEC, WB.
REQ-017 SHALL drive instr_ready = (state==IDLE) && !halt, combinationally.
REQ-018 SHALL capture instr into a 32-bit IR and go IDLE->DECODE on a cycle with instr_valid && instr_ready; otherwise it SHALL remain in IDLE.
REQ-019 SHALL, in DECODE, treat as legal only opcode 0110011 with funct7 0000000 (any funct3), or funct7 0100000 with funct3 000 or 101.
REQ-020 SHALL, on a legal instruction in DECODE, register alu_ctrl and go to EXEC.
REQ-021 SHALL, on an illegal instruction in DECODE, pulse illegal for exactly the next cycle, return to IDLE, and neither write nor retire.
REQ-022 SHALL use this alu_ctrl encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SRL 0101, SRA 0110, SLL 0111, SLT 1000, SLTU 1001.
REQ-023 SHALL hold alu_ctrl stable from EXEC through WB, and keep its last value while in IDLE.
REQ-024 SHALL always go EXEC->WB after exactly one cycle.
REQ-025 SHALL assert rf_we only in WB, for exactly one cycle, and SHALL suppress it when rf_rd==0.
REQ-026 SHALL increment retire_cnt by 1 in every WB cycle, including rd==0, wrapping modulo 2^CNT_W.
REQ-027 SHALL always go WB->IDLE, so the accept-to-write latency is 3 cycles (accept at N, rf_we at N+3) and throughput is one instruction per 4 cycles.
REQ-028 SHALL let halt only gate instr_ready; halt asserted mid-instruction SHALL not abort the instruction or suppress its WB.
REQ-029 SHALL ignore instr_valid and instr while busy, leaving IR unchanged.

Reset
REQ-030 SHALL, with rst_n low at a rising edge, set state=IDLE, IR=0, alu_ctrl=0000, rf_we=0, illegal=0, retire_cnt=0.
REQ-031 SHALL, when reset is applied mid-instruction, abandon that instruction with no rf_we and no retire.
REQ-032 SHALL hold instr_ready at 0 while rst_n is low.

Structure
REQ-033 SHALL take the state enum, alu_ctrl codes, and the OPC_RTYPE/funct7 constants from the shared package riscv_ctrl_pkg.
REQ-034 SHALL place funct3/funct7 decode in one combinational sub-module, riscv_rtype_decoder (inputs funct7, funct3; outputs alu_ctrl, legal).

Verification
REQ-035 SHALL cover: {0000000,x1,x2,000,x3,0110011} accepted at N -> alu_ctrl=0000 at N+2, rf_we=1 with rf_rd=3 at N+3, retire_cnt=1, instr_ready=1 at N+4.
REQ-036 SHALL cover: SUB (funct7 0100000, f3 000) then SRA (0100000, 101) back to back -> alu_ctrl 0001 then 0110, two rf_we pulses 4 cycles apart, retire_cnt=2.
REQ-037 SHALL cover: funct7 0100000 with f3 111, and opcode 0010011 -> illegal pulses one cycle each, no rf_we, retire_cnt unchanged.
REQ-038 SHALL cover: R-type with rd=x0 -> no rf_we, retire_cnt increments.
REQ-039 SHALL cover: halt raised in EXEC -> WB completes, instr_ready stays 0 while halt=1 with instr_valid=1; instr_ready returns 1 the cycle after halt drops.
REQ-040 SHALL cover: rst_n low during EXEC -> next cycle in IDLE, rf_we=0, retire_cnt=0; retire_cnt preset to all-ones, then one WB -> wraps to 0.
